// File: rtl/clkdiv_pkg.sv
// Shared constants for the multi-channel clock divider.
// The optional sync-restart feature is enabled with the CLKDIV_SYNC_EN macro.
package clkdiv_pkg;

  localparam int          CNT_W_DEF       = 29;
  localparam int unsigned DEFAULT_DIV_DEF = 520_833;
  localparam int          MAX_CH          = 16;
  localparam int          IDX_W           = 4;

  // Writes addressed beyond the instantiated channels are dropped.
  function automatic logic ch_in_range(input logic [IDX_W-1:0] idx, input int num_ch);
    int idx_i;
    idx_i = int'(idx);
    return idx_i < num_ch;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, active/shadow divisor, square-wave toggle and tick.
// With CLKDIV_SYNC_EN defined, a restart input phase-aligns the channel.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
`ifdef CLKDIV_SYNC_EN
  input  logic             restart,
`endif
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             clk_out,
  output logic             tick,
  output logic             pend
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic [CNT_W-1:0] shd_q, shd_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             hold;

`ifdef CLKDIV_SYNC_EN
  assign hold = restart || !en;
`else
  assign hold = !en;
`endif

  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    clk_d  = clk_q;
    tick_d = 1'b0;

    if (hold) begin
      // Idle/restart: park low at count zero and adopt any waiting divisor now.
      cnt_d = '0;
      clk_d = 1'b0;
      if (pend_q) begin
        act_d  = shd_q;
        pend_d = 1'b0;
      end
    end else if (cnt_q >= act_q) begin
      cnt_d  = '0;
      clk_d  = ~clk_q;
      tick_d = 1'b1;
      if (pend_q) begin
        act_d  = shd_q;
        pend_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // A write always lands in the shadow; at a terminal count the active
    // divisor above was taken from the old shadow, so the new value waits.
    if (wr) begin
      shd_d  = wr_div;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      act_q  <= CNT_W'(DEFAULT_DIV);
      shd_q  <= CNT_W'(DEFAULT_DIV);
      pend_q <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign pend    = pend_q;

endmodule

// File: rtl/clock_divider_multi.sv
// NUM_CH independent programmable clock dividers with shadowed divisor writes.
// Defining CLKDIV_SYNC_EN adds the sync_restart input for phase alignment.
module clock_divider_multi
  import clkdiv_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
`ifdef CLKDIV_SYNC_EN
  input  logic              sync_restart,
`endif
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pend
);

  logic              wr_ok;
  logic [NUM_CH-1:0] wr_sel;

  assign wr_ok = wr_en && ch_in_range(wr_ch, NUM_CH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_sel[i] = wr_ok && (wr_ch == IDX_W'(i));

    clkdiv_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (ch_en[i]),
`ifdef CLKDIV_SYNC_EN
      .restart (sync_restart),
`endif
      .wr      (wr_sel[i]),
      .wr_div  (wr_div),
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .pend    (pend[i])
    );
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi with NUM_CH=2, DEFAULT_DIV=3.
module tb_clock_divider_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] ch_en;
  logic       wr_en;
  logic [3:0] wr_ch;
  logic [7:0] wr_div;
  logic [1:0] clk_out;
  logic [1:0] tick;
  logic [1:0] pend;
`ifdef CLKDIV_SYNC_EN
  logic       sync_restart;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  clock_divider_multi #(
    .NUM_CH      (2),
    .CNT_W       (8),
    .DEFAULT_DIV (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ch_en        (ch_en),
    .wr_en        (wr_en),
    .wr_ch        (wr_ch),
    .wr_div       (wr_div),
`ifdef CLKDIV_SYNC_EN
    .sync_restart (sync_restart),
`endif
    .clk_out      (clk_out),
    .tick         (tick),
    .pend         (pend)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    ch_en  = 2'b11;
    wr_en  = 1'b0;
    wr_ch  = '0;
    wr_div = '0;
`ifdef CLKDIV_SYNC_EN
    sync_restart = 1'b0;
`endif
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] exp;
    rst    = 1'b1;
    ch_en  = 2'b11;
    wr_en  = 1'b0;
    wr_ch  = '0;
    wr_div = '0;
`ifdef CLKDIV_SYNC_EN
    sync_restart = 1'b0;
`endif
    step();
    vectors++;
    if ({clk_out, tick, pend} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_state got %b required %b", {clk_out, tick, pend}, 6'b0);
    end
    // write coincident with reset must be dropped
    wr_en = 1'b1; wr_ch = 4'd0; wr_div = 8'd1;
    step();
    wr_en = 1'b0;
    rst = 1'b0;
    vectors++;
    if (pend !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_write_pend got %b required %b", pend, 2'b00);
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      exp = (k == 4) ? 6'b11_11_00 : 6'b00_00_00;
      vectors++;
      if ({clk_out, tick, pend} !== exp) begin
        miscompares++;
        $display("FAIL reset_first_toggle k=%0d got %b required %b", k, {clk_out, tick, pend}, exp);
      end
    end
  endtask

  task automatic test_basic();
    logic c, t;
    logic [5:0] exp;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      step();
      c = ((k / 4) % 2) == 1;
      t = (k % 4) == 0;
      exp = {c, c, t, t, 2'b00};
      vectors++;
      if ({clk_out, tick, pend} !== exp) begin
        miscompares++;
        $display("FAIL basic k=%0d got %b required %b", k, {clk_out, tick, pend}, exp);
      end
    end
  endtask

  task automatic test_write_mid();
    logic c0, t0, c1, t1, p0;
    logic [5:0] exp;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      if (k == 3) begin wr_en = 1'b1; wr_ch = 4'd0; wr_div = 8'd1; end
      step();
      wr_en = 1'b0;
      c1 = ((k / 4) % 2) == 1;
      t1 = (k % 4) == 0;
      if (k < 4) begin c0 = 1'b0; t0 = 1'b0; end
      else begin c0 = (((k - 4) / 2) % 2) == 0; t0 = (k % 2) == 0; end
      p0 = (k == 3);
      exp = {c1, c0, t1, t0, 1'b0, p0};
      vectors++;
      if ({clk_out, tick, pend} !== exp) begin
        miscompares++;
        $display("FAIL write_mid k=%0d got %b required %b", k, {clk_out, tick, pend}, exp);
      end
    end
  endtask

  task automatic test_write_tc();
    logic c0, t0, c1, t1, p0;
    logic [5:0] exp;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      if (k == 4) begin wr_en = 1'b1; wr_ch = 4'd0; wr_div = 8'd1; end
      step();
      wr_en = 1'b0;
      c1 = ((k / 4) % 2) == 1;
      t1 = (k % 4) == 0;
      if (k < 4) begin c0 = 1'b0; t0 = 1'b0; end
      else if (k < 8) begin c0 = 1'b1; t0 = (k == 4); end
      else begin c0 = (((k - 8) / 2) % 2) == 1; t0 = (k % 2) == 0; end
      p0 = (k >= 4) && (k < 8);
      exp = {c1, c0, t1, t0, 1'b0, p0};
      vectors++;
      if ({clk_out, tick, pend} !== exp) begin
        miscompares++;
        $display("FAIL write_tc k=%0d got %b required %b", k, {clk_out, tick, pend}, exp);
      end
    end
  endtask

  task automatic test_div0_bad_ch();
    logic c0, t0, c1, t1, p1;
    logic [5:0] exp;
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      if (k == 2) begin wr_en = 1'b1; wr_ch = 4'd5; wr_div = 8'd0; end
      if (k == 9) begin wr_en = 1'b1; wr_ch = 4'd1; wr_div = 8'd0; end
      step();
      wr_en = 1'b0;
      c0 = ((k / 4) % 2) == 1;
      t0 = (k % 4) == 0;
      if (k < 12) begin c1 = c0; t1 = t0; end
      else begin c1 = ((k - 12) % 2) == 0; t1 = 1'b1; end
      p1 = (k >= 9) && (k < 12);
      exp = {c1, c0, t1, t0, p1, 1'b0};
      vectors++;
      if ({clk_out, tick, pend} !== exp) begin
        miscompares++;
        $display("FAIL div0_bad_ch k=%0d got %b required %b", k, {clk_out, tick, pend}, exp);
      end
    end
  endtask

  task automatic test_disable_reenable();
    logic c0, t0, c1, t1, p1;
    logic [5:0] exp;
    do_reset();
    for (int k = 1; k <= 25; k++) begin
      ch_en[1] = !(((k >= 6) && (k <= 15)) || ((k >= 20) && (k <= 22)));
      if (k == 21) begin wr_en = 1'b1; wr_ch = 4'd1; wr_div = 8'd1; end
      step();
      wr_en = 1'b0;
      c0 = ((k / 4) % 2) == 1;
      t0 = (k % 4) == 0;
      if (k <= 5) begin c1 = c0; t1 = t0; end
      else if (k == 19 || k == 24) begin c1 = 1'b1; t1 = 1'b1; end
      else if (k == 25) begin c1 = 1'b1; t1 = 1'b0; end
      else begin c1 = 1'b0; t1 = 1'b0; end
      p1 = (k == 21);
      exp = {c1, c0, t1, t0, p1, 1'b0};
      vectors++;
      if ({clk_out, tick, pend} !== exp) begin
        miscompares++;
        $display("FAIL disable_reenable k=%0d got %b required %b", k, {clk_out, tick, pend}, exp);
      end
    end
    ch_en = 2'b11;
  endtask

  task automatic test_reset_mid();
    logic c, t;
    logic [5:0] exp;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      rst = (k == 6);
      if (k == 5) begin wr_en = 1'b1; wr_ch = 4'd0; wr_div = 8'd1; end
      if (k == 6) begin wr_en = 1'b1; wr_ch = 4'd1; wr_div = 8'd0; end
      step();
      wr_en = 1'b0;
      if (k <= 5) begin
        c = ((k / 4) % 2) == 1;
        t = (k % 4) == 0;
        exp = {c, c, t, t, 1'b0, (k == 5)};
      end else if (k < 10) begin
        exp = 6'b00_00_00;
      end else begin
        exp = {2'b11, (k == 10), (k == 10), 2'b00};
      end
      vectors++;
      if ({clk_out, tick, pend} !== exp) begin
        miscompares++;
        $display("FAIL reset_mid k=%0d got %b required %b", k, {clk_out, tick, pend}, exp);
      end
    end
    rst = 1'b0;
  endtask

`ifdef CLKDIV_SYNC_EN
  task automatic test_sync_restart();
    logic c, t;
    logic [5:0] exp;
    do_reset();
    for (int k = 1; k <= 15; k++) begin
      sync_restart = (k == 7);
      if (k == 6) begin wr_en = 1'b1; wr_ch = 4'd1; wr_div = 8'd5; end
      step();
      wr_en = 1'b0;
      c = ((k / 4) % 2) == 1;
      t = (k % 4) == 0;
      case (k)
        6:       exp = {c, c, t, t, 2'b10};
        11:      exp = 6'b01_01_00;
        12:      exp = 6'b01_00_00;
        13:      exp = 6'b11_10_00;
        14:      exp = 6'b11_00_00;
        15:      exp = 6'b10_01_00;
        default: exp = (k < 6) ? {c, c, t, t, 2'b00} : 6'b00_00_00;
      endcase
      vectors++;
      if ({clk_out, tick, pend} !== exp) begin
        miscompares++;
        $display("FAIL sync_restart k=%0d got %b required %b", k, {clk_out, tick, pend}, exp);
      end
    end
    sync_restart = 1'b0;
  endtask
`endif

  initial begin
    rst    = 1'b1;
    ch_en  = 2'b00;
    wr_en  = 1'b0;
    wr_ch  = '0;
    wr_div = '0;
`ifdef CLKDIV_SYNC_EN
    sync_restart = 1'b0;
`endif
    test_reset();
    test_basic();
    test_write_mid();
    test_write_tc();
    test_div0_bad_ch();
    test_disable_reenable();
    test_reset_mid();
`ifdef CLKDIV_SYNC_EN
    test_sync_restart();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clock_divider_multi.md
CLOCK_DIVIDER_MULTI -- requirements
Module: clock_divider_multi

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent divider channels, 1..16.
REQ-002 Parameter CNT_W, default 29: counter and divisor width in bits.
REQ-003 Parameter DEFAULT_DIV, default 520_833: divisor loaded into every channel at reset.
REQ-004 Port clk  input  1: single clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port rst  input  1: synchronous, active-high reset.
REQ-006 Port ch_en  input  NUM_CH: per-channel run enable.
REQ-007 Port wr_en  input  1: divisor write strobe, one cycle per write.
REQ-008 Port wr_ch  input  4: target channel index for the write.
REQ-009 Port wr_div  input  CNT_W: new divisor value.
REQ-010 Port clk_out  output  NUM_CH: registered square-wave outputs.
REQ-011 Port tick  output  NUM_CH: registered one-cycle pulse, asserted on each clk_out toggle.
REQ-012 Port pend  output  NUM_CH: a written divisor is waiting to take effect.

Function
REQ-013 Each channel SHALL hold a CNT_W counter, an active divisor and a shadow divisor.
REQ-014 Enabled channel: if counter >= active divisor, then counter <= 0, clk_out toggles and tick = 1 for the next cycle; otherwise counter increments and tick = 0.
REQ-015 Output period SHALL be 2*(div+1) clk cycles with a 50% duty cycle.
REQ-016 div = 0: clk_out SHALL toggle every cycle and tick SHALL be held high continuously.
REQ-017 Write with wr_ch < NUM_CH: shadow <= wr_div and pend[wr_ch] <= 1 in the next cycle.
REQ-018 Write with wr_ch >= NUM_CH: SHALL be ignored, with no state change.
REQ-019 Enabled channel with pend = 1: at the next terminal count, active <= shadow and pend <= 0.
REQ-020 Write in the same cycle as a terminal count: the value goes to shadow only; it SHALL take effect at the following terminal count.
REQ-021 Back-to-back writes to one channel: the last write wins.
REQ-022 Disabled channel: counter = 0, clk_out = 0, tick = 0; a pending shadow value is applied immediately and pend clears.
REQ-023 Channel re-enabled: counting restarts from 0 with clk_out low; the first toggle SHALL occur div+1 cycles after ch_en rises.
REQ-024 Counter comparison SHALL be unsigned, with no overflow possible, because the counter never exceeds the divisor.

Reset
REQ-025 rst SHALL take priority over every other input, including a write in the same cycle.
REQ-026 During rst: counters = 0, clk_out = 0, tick = 0, pend = 0, active = shadow = DEFAULT_DIV.
REQ-027 Reset mid-period SHALL discard partial counts; the first toggle comes DEFAULT_DIV+1 cycles after rst deasserts, if the channel is enabled.

Configuration
REQ-028 Macro CLKDIV_SYNC_EN, when defined, SHALL add input port sync_restart (1 bit).
REQ-029 With the macro defined, sync_restart = 1 SHALL zero all counters, force clk_out = 0, apply pending shadows and clear pend, phase-aligning every enabled channel.
REQ-030 Without the macro, the port and its logic SHALL be absent and behaviour SHALL be exactly REQ-013..027.

Structure
REQ-031 Package clkdiv_pkg SHALL hold CNT_W default, DEFAULT_DIV, the maximum NUM_CH (16) and the index width constant (4).
REQ-032 Sub-module clkdiv_channel SHALL implement one channel (counter, divisor registers, toggle, tick, pend); the top module SHALL instantiate NUM_CH copies and decode writes.

Verification
REQ-033 NUM_CH=2, DEFAULT_DIV=3, ch_en=11 after reset -> clk_out period 8 cycles, tick every 4 cycles, first toggle 4 cycles after rst low.
REQ-034 Write div=1 to ch0 mid-period -> pend[0]=1 until the next terminal count; period changes from 8 to 4 cycles, ch1 is unaffected.
REQ-035 Write coincident with the terminal count -> the old period is repeated once, then the new period applies.
REQ-036 Write div=0 -> toggle every cycle, tick constantly 1; a write with wr_ch=5 -> no change on any output.
REQ-037 ch_en[1] low for 10 cycles then high -> clk_out[1]=0 while low; first toggle 4 cycles after re-enable; rst asserted mid-period -> all outputs 0 next cycle.
REQ-038 With CLKDIV_SYNC_EN, div 3 and 5, pulse sync_restart -> both channels low, then toggle at +4 and +6 cycles from a common origin.
